// File: rtl/pp_adder_pkg.sv
// pp_adder_pkg: shared types and helpers for the pipelined parallel-prefix adder.
package pp_adder_pkg;

    // Generate/propagate pair carried by each prefix node.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Ceiling log2 usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Edges from accept to out_valid: one operand stage plus one register per prefix group.
    function automatic int unsigned ppa_lat(input int unsigned width, input int unsigned reg_every);
        return 1 + (clog2(width) + reg_every - 1) / reg_every;
    endfunction

    // Prefix operator: hi is the more significant span, lo the span just below it.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/pp_prefix_level.sv
// pp_prefix_level: one combinational Kogge-Stone level; bit i merges with bit i-DIST.
module pp_prefix_level
    import pp_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < DIST) begin : g_pass
            // Span already reaches bit 0; nothing below to merge.
            assign o_g[i] = i_g[i];
            assign o_p[i] = i_p[i];
        end else begin : g_node
            gp_t w_hi;
            gp_t w_lo;
            gp_t w_node;
            assign w_hi   = {i_g[i], i_p[i]};
            assign w_lo   = {i_g[i-DIST], i_p[i-DIST]};
            assign w_node = gp_combine(w_hi, w_lo);
            assign o_g[i] = w_node.g;
            assign o_p[i] = w_node.p;
        end
    end
endmodule

// File: rtl/pp_adder_pipe.sv
// pp_adder_pipe: pipelined Kogge-Stone adder/subtractor with elastic valid/ready stages.
// Saturation on signed overflow is built only when PPA_SAT_EN is defined.
module pp_adder_pipe
    import pp_adder_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef PPA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned L   = clog2(WIDTH);
    localparam int unsigned NG  = (L + REG_EVERY - 1) / REG_EVERY;  // prefix register groups
    localparam int unsigned LAT = ppa_lat(WIDTH, REG_EVERY);          // NG prefix regs + output

    // Stage s in 0..NG-1 holds the prefix state entering group s; stage NG is the output.
    logic [WIDTH-1:0] r_g    [NG];
    logic [WIDTH-1:0] r_p    [NG];
    logic [WIDTH-1:0] r_praw [NG];  // half-sum bits, needed for the final XOR
    logic             r_c0   [NG];
`ifdef PPA_SAT_EN
    logic             r_sat  [NG];
    logic             r_amsb [NG];
`endif
    logic [LAT-1:0]   r_vld;
    logic             w_en   [LAT+1];

    logic [WIDTH-1:0] w_g_lvl [L];
    logic [WIDTH-1:0] w_p_lvl [L];

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_p0;
    logic             w_c0;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic             w_unused_p;

    // Elastic enable chain: a stage may load if it is empty or the stage after it moves.
    assign w_en[LAT] = out_ready;
    for (genvar s = 0; s < LAT; s++) begin : g_en
        assign w_en[s] = ~r_vld[s] | w_en[s+1];
    end

    assign in_ready  = w_en[0] & ~reset;
    assign out_valid = r_vld[LAT-1];

    // Valid bits advance with their stage enables; reset empties the pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld <= '0;
        end else begin
            if (w_en[0]) begin
                r_vld[0] <= in_valid;
            end
            for (int s = 1; s < int'(LAT); s++) begin
                if (w_en[s]) begin
                    r_vld[s] <= r_vld[s-1];
                end
            end
        end
    end

    // Operand conditioning: invert b for subtract and fold the carry-in into bit 0.
    always_comb begin
        w_b     = sub ? ~b : b;
        w_c0    = sub | cin;
        w_p0    = a ^ w_b;
        w_g0    = a & w_b;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
    end

    // Prefix levels; a group starts from its stage register, later levels chain combinationally.
    for (genvar k = 0; k < L; k++) begin : g_level
        logic [WIDTH-1:0] w_gi;
        logic [WIDTH-1:0] w_pi;
        if (k % REG_EVERY == 0) begin : g_from_reg
            assign w_gi = r_g[k/REG_EVERY];
            assign w_pi = r_p[k/REG_EVERY];
        end else begin : g_from_comb
            assign w_gi = w_g_lvl[k-1];
            assign w_pi = w_p_lvl[k-1];
        end
        pp_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_level (
            .i_g (w_gi),
            .i_p (w_pi),
            .o_g (w_g_lvl[k]),
            .o_p (w_p_lvl[k])
        );
    end

    // Stage registers: operand stage, then one register at the end of each non-final group.
    always_ff @(posedge clk) begin
        if (w_en[0]) begin
            r_g[0]    <= w_g0;
            r_p[0]    <= w_p0;
            r_praw[0] <= w_p0;
            r_c0[0]   <= w_c0;
`ifdef PPA_SAT_EN
            r_sat[0]  <= sat;
            r_amsb[0] <= a[WIDTH-1];
`endif
        end
        for (int j = 1; j < int'(NG); j++) begin
            if (w_en[j]) begin
                r_g[j]    <= w_g_lvl[j*int'(REG_EVERY)-1];
                r_p[j]    <= w_p_lvl[j*int'(REG_EVERY)-1];
                r_praw[j] <= r_praw[j-1];
                r_c0[j]   <= r_c0[j-1];
`ifdef PPA_SAT_EN
                r_sat[j]  <= r_sat[j-1];
                r_amsb[j] <= r_amsb[j-1];
`endif
            end
        end
    end

    // Final group tail: carries into each bit, sum XOR, flags and optional clamp.
    always_comb begin
        w_carry    = {w_g_lvl[L-1], r_c0[NG-1]};
        w_ovf      = w_carry[WIDTH] ^ w_carry[WIDTH-1];
        w_sum      = r_praw[NG-1] ^ w_carry[WIDTH-1:0];
        // Group propagate of the last level is not needed once carries are resolved.
        w_unused_p = ^w_p_lvl[L-1];
`ifdef PPA_SAT_EN
        if (r_sat[NG-1] && w_ovf) begin
            w_sum = r_amsb[NG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Output register; holds while the consumer stalls a valid result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (w_en[NG]) begin
            sum  <= w_sum;
            cout <= w_carry[WIDTH];
            ovf  <= w_ovf;
        end
    end

endmodule
